load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Multi-cycle load/store stage sitting directly downstream of the datapath. It consumes alu_result (address), write_data (store data) and the memory-control bits, and returns the formatted read_data the datapath routes into its result mux. It drives a word-wide memory bus with a req/ready handshake and wait states, and it raises stall so the core holds the PC and register writes until the access completes.

Parameters:
TIMEOUT_CYCLES, 255, bus wait cycles before abort (used only when LSU_TIMEOUT_EN is defined); 8-bit counter range, legal values 1..255.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
mem_read  input  1  current instruction is a load
mem_write  input  1  current instruction is a store
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  32  byte address (datapath alu_result)
store_data  input  32  store operand (datapath write_data)
read_data  output  32  sign/zero-extended load result, to datapath
stall  output  1  core must hold PC and suppress reg_write
misaligned  output  1  one-cycle pulse on misaligned access
bus_req  output  1  bus request
bus_we  output  1  1 = write
bus_addr  output  32  word-aligned address, addr[1:0] forced to 00
bus_wdata  output  32  lane-replicated store data
bus_wstrb  output  4  byte-lane write strobes
bus_rdata  input  32  read data, valid when bus_ready=1
bus_ready  input  1  bus completes the access this cycle
bus_err  output  1  timeout abort pulse (LSU_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (reset=0 at posedge): FSM -> IDLE; bus_req, bus_we, bus_wstrb, misaligned, bus_err = 0; read_data, bus_addr, bus_wdata = 0. A reset during BUSY drops bus_req at that edge, and the in-flight access is abandoned.
- FSM states: IDLE, BUSY, DONE.
- IDLE: if mem_read|mem_write and the access is aligned -> register bus_addr, bus_we, bus_wdata, bus_wstrb, funct3 and addr[1:0]; go to BUSY. stall = 1 combinationally in this cycle.
- Misaligned = H/HU with addr[0]=1, or W with addr[1:0]≠0. No bus request is issued; misaligned pulses for one cycle (registered); stall = 0; read_data = 0; the store is dropped; the FSM stays in IDLE.
- mem_read and mem_write both high: treated as a store.
- funct3 values 011, 110, 111: treated as word access.
- BUSY: bus_req = 1; bus_addr, bus_we, bus_wdata and bus_wstrb are held stable until bus_ready is sampled 1. stall = 1. On bus_ready -> latch the formatted load result into read_data (stores leave read_data unchanged) and go to DONE.
- DONE: stall = 0 for exactly one cycle so the core retires the instruction. read_data is held. The state always returns to IDLE, and a new access is only recognised in IDLE.
- Minimum access latency is 2 cycles of stall plus 1 DONE cycle. With N wait cycles, stall lasts N+2 cycles.
- Store lanes:
  - SB: wdata = {4{byte}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{half}}, wstrb = 0011 << addr[1:0].
  - SW: wstrb = 1111.
- Load extract: select the byte/half by the registered addr[1:0]. B/H sign-extend from bit 7/15; BU/HU zero-extend.
- bus_ready while bus_req = 0 is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: an 8-bit counter clears on entry to BUSY and increments each BUSY cycle without bus_ready. When it reaches TIMEOUT_CYCLES: bus_req drops, bus_err pulses for 1 cycle, read_data = 32'hDEAD_BEEF, and the FSM goes to DONE.
- Not defined: no counter; bus_err is tied 0; BUSY waits indefinitely.

Decomposition:
- Shared package: funct3 encodings (LSU_B/H/W/BU/HU), FSM state encoding, DEAD_BEEF fill constant.
- One natural sub-module, lsu_align: combinational store-lane replication/strobe generation plus load extract/extend. This keeps the FSM file sequential-only.

Test Plan:
- SW addr=0x100, data=0x11223344, bus_ready after 3 wait cycles -> bus_addr=0x100, wstrb=1111, wdata=0x11223344 held stable, stall high 5 cycles, then DONE.
- LB addr=0x203, bus_rdata=0x80FF_FF00, ready immediately -> read_data=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH addr=0x102, data=0x0000_ABCD -> wdata=0xABCD_ABCD, wstrb=1100. LH addr=0x101 -> misaligned pulse, no bus_req, stall=0.
- Reset asserted low in the 2nd BUSY cycle of an LW -> bus_req=0 and FSM in IDLE after that edge. After release, a new LW completes normally.
- mem_read and mem_write both high, SB addr=0x3 -> store issued, wstrb=1000, read_data unchanged.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ready held 0 -> bus_err pulses after 4 BUSY cycles, read_data=0xDEADBEEF, stall releases. Without the macro, stall stays high.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states, abort fill.
package load_store_unit_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication/strobes/misalignment and load extract/extend.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_offset,
    input  logic [31:0] store_data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] load_value
);

    logic [31:0] shifted;

    // Unsigned encodings share the lane logic of their signed counterparts on the store side.
    always_comb begin
        wdata      = store_data;
        wstrb      = 4'b1111;
        misaligned = 1'b0;
        case (st_funct3)
            LSU_B, LSU_BU: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << st_offset;
            end
            LSU_H, LSU_HU: begin
                wdata      = {2{store_data[15:0]}};
                wstrb      = 4'b0011 << st_offset;
                misaligned = st_offset[0];
            end
            default: misaligned = |st_offset;
        endcase
    end

    always_comb begin
        shifted = rdata >> {ld_offset, 3'b000};
        case (ld_funct3)
            LSU_B:   load_value = {{24{shifted[7]}}, shifted[7:0]};
            LSU_BU:  load_value = {24'h0, shifted[7:0]};
            LSU_H:   load_value = {{16{shifted[15]}}, shifted[15:0]};
            LSU_HU:  load_value = {16'h0, shifted[15:0]};
            default: load_value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage with req/ready bus and core stall.
// Optional bus timeout abort enabled by defining LSU_TIMEOUT_EN.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        misaligned,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready,
    output logic        bus_err,
    output lsu_state_e  debug_state
);

    lsu_state_e  state_q, state_d;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata, load_value;
    logic [3:0]  wstrb;
    logic        access_misaligned, start, mis_start, timeout_hit;

    lsu_align u_align (
        .st_funct3  (funct3),
        .st_offset  (addr[1:0]),
        .store_data (store_data),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .misaligned (access_misaligned),
        .ld_funct3  (funct3_q),
        .ld_offset  (offset_q),
        .rdata      (bus_rdata),
        .load_value (load_value)
    );

    assign bus_req     = (state_q == BUSY);
    assign debug_state = state_q;

    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        start     = 1'b0;
        mis_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (access_misaligned) begin
                        mis_start = 1'b1;
                    end else begin
                        start   = 1'b1;
                        stall   = 1'b1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (bus_ready || timeout_hit) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;

    // Counter holds the number of BUSY cycles already spent without bus_ready.
    assign timeout_hit = (state_q == BUSY) && !bus_ready && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= 8'h0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= timeout_hit;
            if (start) wait_cnt <= 8'h0;
            else if (state_q == BUSY && !bus_ready) wait_cnt <= wait_cnt + 8'h1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            funct3_q   <= 3'b000;
            offset_q   <= 2'b00;
            read_data  <= 32'h0;
            misaligned <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= 32'h0;
            bus_wdata  <= 32'h0;
            bus_wstrb  <= 4'h0;
        end else begin
            state_q    <= state_d;
            misaligned <= mis_start;
            if (mis_start) read_data <= 32'h0;
            if (start) begin
                bus_addr  <= {addr[31:2], 2'b00};
                bus_we    <= mem_write;
                bus_wdata <= wdata;
                bus_wstrb <= mem_write ? wstrb : 4'h0;
                funct3_q  <= funct3;
                offset_q  <= addr[1:0];
            end
            if (state_q == BUSY && bus_ready && !bus_we) read_data <= load_value;
            if (timeout_hit) read_data <= DEAD_BEEF;
        end
    end

endmodule
